gcd_lcm_engine: RTL and testbench

- Parametrised, multi-cycle GCD/LCM coprocessor. Successor to the fixed-width, start-only coprocessor hanging off the single-cycle core.
- Adds a selectable operation (GCD or LCM), a start/busy/done handshake, zero-operand handling, and a registered result with an overflow flag.
- Sits beside dmem; the core's store path drives operands and start, and the core reads result back on the load path.
- Arithmetic is iterative: subtractive Euclid, then restoring divide, then shift-add multiply.

---
 rtl/gcd_lcm_engine.sv | 150 +++++++++++++++
 tb/tb_gcd_lcm_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle GCD/LCM coprocessor. It computes the GCD by subtractive Euclid. For LCM it then
// forms A/g by restoring division and (A/g)*B by shift-add into a double-width product.
module gcd_lcm_engine #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StGcd, StDiv, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic               op_q;
  logic [WIDTH-1:0]   a_q, b_q, x_q, y_q, dq_q, rem_q, result_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               ovf_q;

  logic               zero_op, xy_eq, cnt_last, rem_ge;
  logic [WIDTH:0]     rem_sh, mul_add;
  logic [WIDTH-1:0]   rem_sub, q_final;
  logic [2*WIDTH-1:0] mul_next;

  assign zero_op  = (x_q == '0) || (y_q == '0);
  assign xy_eq    = (x_q == y_q);
  assign cnt_last = (cnt_q == CntLast);

  // Once GCD finishes, x_q holds g and serves as the divisor.
  assign rem_sh   = {rem_q, dq_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, x_q};
  assign rem_sub  = rem_sh[WIDTH-1:0] - x_q;
  assign q_final  = {dq_q[WIDTH-2:0], rem_ge};

  // The low half of the product register starts as the multiplier and is shifted out LSB first.
  assign mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? b_q : '0)};
  assign mul_next = {mul_add, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StGcd;
      StGcd: begin
        if (zero_op)    state_d = StDone;
        else if (xy_eq) state_d = op_q ? StDiv : StDone;
      end
      StDiv:  if (cnt_last) state_d = StMul;
      StMul:  if (cnt_last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StGcd, StDiv, StMul: busy = 1'b1;
      StDone:              done = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;
  assign ovf    = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q  <= op;
            a_q   <= opa;
            b_q   <= opb;
            x_q   <= opa;
            y_q   <= opb;
            ovf_q <= 1'b0;
          end
        end
        StGcd: begin
          // Zero operands are checked first; subtracting with a zero side would never converge.
          if (zero_op) begin
            result_q <= op_q ? '0 : (x_q | y_q);
          end else if (xy_eq) begin
            if (!op_q) begin
              result_q <= x_q;
            end else begin
              dq_q  <= a_q;
              rem_q <= '0;
              cnt_q <= '0;
            end
          end else if (x_q > y_q) begin
            x_q <= x_q - y_q;
          end else begin
            y_q <= y_q - x_q;
          end
        end
        StDiv: begin
          rem_q <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          dq_q  <= q_final;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_last) begin
            prod_q <= {{WIDTH{1'b0}}, q_final};
            cnt_q  <= '0;
          end
        end
        StMul: begin
          prod_q <= mul_next;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_last) begin
            result_q <= mul_next[WIDTH-1:0];
            ovf_q    <= |mul_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Scoreboard bench for gcd_lcm_engine: the drivers push expected result, ovf and latency.
// The monitors pop and compare those entries on every done pulse, one engine at WIDTH=32 and one at WIDTH=8.
module tb_gcd_lcm_engine;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          k;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        start32 = 1'b0, op32 = 1'b0;
  logic [31:0] opa32 = '0, opb32 = '0, result32;
  logic        busy32, done32, ovf32;

  logic        start8 = 1'b0, op8 = 1'b0;
  logic [7:0]  opa8 = '0, opb8 = '0, result8;
  logic        busy8, done8, ovf8;

  exp_t        q32[$];
  exp_t        q8[$];
  int          done_cnt32 = 0;
  int          last_k32 = 0;

  gcd_lcm_engine #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .op(op32), .opa(opa32), .opb(opb32),
    .busy(busy32), .done(done32), .result(result32), .ovf(ovf32)
  );

  gcd_lcm_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .op(op8), .opa(opa8), .opb(opb8),
    .busy(busy8), .done(done8), .result(result8), .ovf(ovf8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done32) begin
      exp_t e;
      done_cnt32++;
      if (q32.size() == 0) begin
        chk("w32 unexpected done", 64'(done32), 64'(0));
      end else begin
        e = q32.pop_front();
        chk("w32 result", 64'(result32), 64'(e.res));
        chk("w32 ovf", 64'(ovf32), 64'(e.ovf));
        chk("w32 latency", 64'(cyc - e.k), 64'(e.lat));
        chk("w32 busy with done", 64'(busy32), 64'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      exp_t e;
      if (q8.size() == 0) begin
        chk("w8 unexpected done", 64'(done8), 64'(0));
      end else begin
        e = q8.pop_front();
        chk("w8 result", 64'(result8), 64'(e.res[7:0]));
        chk("w8 ovf", 64'(ovf8), 64'(e.ovf));
        chk("w8 latency", 64'(cyc - e.k), 64'(e.lat));
      end
    end
  end

  task automatic issue32(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic v, input int lat);
    @(negedge clk);
    op32 = o; opa32 = a; opb32 = b; start32 = 1'b1;
    last_k32 = cyc + 1;
    q32.push_back('{res: r, ovf: v, k: cyc + 1, lat: lat});
    @(negedge clk);
    start32 = 1'b0;
    chk("w32 busy after accept", 64'(busy32), 64'(1));
  endtask

  task automatic wait32();
    int n = 0;
    while (q32.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    start32 = 1'b0;
    if (q32.size() != 0) begin
      chk("w32 done timeout", 64'(q32.size()), 64'(0));
      q32.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue8(input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic v, input int lat);
    int n = 0;
    @(negedge clk);
    op8 = o; opa8 = a; opb8 = b; start8 = 1'b1;
    q8.push_back('{res: {24'b0, r}, ovf: v, k: cyc + 1, lat: lat});
    @(negedge clk);
    start8 = 1'b0;
    while (q8.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      chk("w8 done timeout", 64'(q8.size()), 64'(0));
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int snap;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy32), 64'(0));
    chk("reset done", 64'(done32), 64'(0));
    chk("reset result", 64'(result32), 64'(0));
    chk("reset ovf", 64'(ovf32), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // op, a, b, result, ovf, latency = 1 + subtract steps (+ 2*WIDTH for LCM)
    issue32(1'b0, 12, 18, 6, 1'b0, 3);        wait32();
    issue32(1'b1, 4, 6, 12, 1'b0, 67);        wait32();
    issue32(1'b0, 17, 5, 1, 1'b0, 7);         wait32();
    issue32(1'b1, 3, 5, 15, 1'b0, 68);        wait32();
    issue32(1'b0, 0, 7, 7, 1'b0, 1);          wait32();
    issue32(1'b1, 0, 7, 0, 1'b0, 1);          wait32();
    issue32(1'b0, 0, 0, 0, 1'b0, 1);          wait32();
    issue32(1'b1, 0, 0, 0, 1'b0, 1);          wait32();

    // 200*201 = 40200 = 0x9D08; gcd chain takes 200 subtracts.
    issue8(1'b1, 8'd200, 8'd201, 8'd8, 1'b1, 217);
    issue8(1'b0, 8'd9, 8'd9, 8'd9, 1'b0, 1);

    // Start pulsed mid-operation is ignored; a held start is taken on the first IDLE edge,
    // which is two edges after the done cycle of the LCM (k+67 -> DONE, k+68 -> IDLE).
    issue32(1'b1, 4, 6, 12, 1'b0, 67);
    repeat (5) @(negedge clk);
    op32 = 1'b0; opa32 = 100; opb32 = 50; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    start32 = 1'b1;
    q32.push_back('{res: 32'd50, ovf: 1'b0, k: last_k32 + 69, lat: 2});
    wait32();

    // Asynchronous reset mid-DIV clears outputs before the next edge and kills the operation.
    issue32(1'b1, 4, 6, 12, 1'b0, 67);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(busy32), 64'(0));
    chk("async reset done", 64'(done32), 64'(0));
    chk("async reset result", 64'(result32), 64'(0));
    chk("async reset ovf", 64'(ovf32), 64'(0));
    q32.delete();
    #4 rst_n = 1'b1;
    snap = done_cnt32;
    repeat (80) @(negedge clk);
    chk("no done after reset", 64'(done_cnt32 - snap), 64'(0));
    issue32(1'b0, 21, 14, 7, 1'b0, 3);       wait32();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
